mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read unified memory (word-addressed, 1-cycle read latency) between the instruction-fetch requester and the load/store requester of the RV32I multicycle core.
- Data has priority, with a starvation guard for fetch.
- Issues at most one memory access per cycle and routes each response back to its owner one cycle later.
- Supports dropping an in-flight fetch on redirect.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 23 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Optional error reporting is compiled in with MEM_ARB_ERR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Byte address to word index; callers truncate to the memory depth.
  function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

  // Byte enables that touch lanes below the start offset cannot belong to this access.
  function automatic logic be_misaligned(input logic [3:0] be, input logic [1:0] off);
    logic [3:0] below;
    below = (4'h1 << off) - 4'h1;
    return |(be & below);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant decision: data first, fetch forced once starvation limit is hit.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          if_req_i,
  input  logic          d_req_i,
  input  logic          if_flush_i,
  input  logic [CW-1:0] starve_cnt_i,
  output logic          if_gnt_o,
  output logic          d_gnt_o
);

  logic fetch_ok;
  logic force_if;

  // A flushing fetch is held off so the redirected request can be presented first.
  assign fetch_ok = if_req_i & ~if_flush_i;
  assign force_if = fetch_ok & (starve_cnt_i == CW'(STARVE_LIMIT));
  assign d_gnt_o  = d_req_i & ~force_if;
  assign if_gnt_o = fetch_ok & ~d_gnt_o;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to one synchronous-read memory port.
// Define MEM_ARB_ERR_EN to add if_err/d_err for misaligned or out-of-range accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_WORDS   = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = $clog2(ADDR_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
`ifdef MEM_ARB_ERR_EN
  output logic            if_err,
  output logic            d_err,
`endif
  output logic            mem_en,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          if_gnt_raw;
  logic          d_gnt_raw;
  logic          if_bad;
  logic          d_bad;
  logic          err_now;
  logic          resp_err;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic          unused_addr_bits;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CW           (CW)
  ) u_prio (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .if_flush_i   (if_flush),
    .starve_cnt_i (starve_cnt_q),
    .if_gnt_o     (if_gnt_raw),
    .d_gnt_o      (d_gnt_raw)
  );

  assign if_gnt = if_gnt_raw & ~rst;
  assign d_gnt  = d_gnt_raw & ~rst;

`ifdef MEM_ARB_ERR_EN
  logic err_q;

  assign if_bad = (|if_addr[1:0]) | (if_addr[XLEN-1:2] >= (XLEN-2)'(ADDR_WORDS));
  assign d_bad  = be_misaligned(d_be, d_addr[1:0]) |
                  (d_addr[XLEN-1:2] >= (XLEN-2)'(ADDR_WORDS));
  assign err_now  = (if_gnt & if_bad) | (d_gnt & d_bad);
  assign resp_err = err_q;
  assign if_err   = if_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;

  always_ff @(posedge clk) begin
    err_q <= err_now;
  end
`else
  assign if_bad   = 1'b0;
  assign d_bad    = 1'b0;
  assign err_now  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Memory command is issued in the grant cycle; bad accesses never reach the array.
  assign mem_en    = (if_gnt & ~if_bad) | (d_gnt & ~d_bad);
  assign mem_we    = d_gnt & d_we & ~d_bad;
  assign mem_be    = d_gnt ? d_be : (if_gnt ? BE_FULL : 4'h0);
  assign mem_addr  = d_gnt ? AW'(word_idx(d_addr)) : AW'(word_idx(if_addr));
  assign mem_wdata = d_wdata;

  assign unused_addr_bits = ^{if_addr, d_addr, err_now};

  always_comb begin
    owner_d      = OWN_NONE;
    we_d         = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (d_gnt) begin
      owner_d = OWN_D;
      we_d    = d_we;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
    we_q <= we_d;
  end

  // Response stage: memory data lands one cycle after the grant and is steered to its owner.
  assign if_rvalid = (owner_q == OWN_IF) & ~if_flush & ~rst;
  assign d_rvalid  = (owner_q == OWN_D) & ~rst;
  assign if_rdata  = (if_rvalid & ~resp_err) ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid & ~we_q & ~resp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef MEM_ARB_ERR_EN
  logic        if_err, d_err;
`endif

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARB_ERR_EN
    .if_err(if_err), .d_err(d_err),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = 4'h0;
  endtask

  task automatic test_reset;
    rst = 1; if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; if_addr = 32'h8; d_addr = 32'h10;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
    n_cmp++; if (d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_err++; $display("FAIL rst_mem_en_we: got %b want 00", {mem_en, mem_we}); end
    n_cmp++; if ({if_rvalid, d_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {if_rvalid, d_rvalid}); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
    idle();
    step();
    rst = 0;
    step();
  endtask

  task automatic test_fetch_only;
    if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    n_cmp++; if ({if_gnt, d_gnt} !== 2'b10) begin n_err++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt}); end
    n_cmp++; if (mem_addr !== 10'd2) begin n_err++; $display("FAIL fetch_mem_addr: got %0d want 2", mem_addr); end
    n_cmp++; if ({mem_en, mem_we, mem_be} !== 6'b101111) begin n_err++; $display("FAIL fetch_mem_cmd: got %b want 101111", {mem_en, mem_we, mem_be}); end
    step();
    if_req = 0;
    @(negedge clk);
    n_cmp++; if (if_rvalid !== 1'b1) begin n_err++; $display("FAIL fetch_rvalid: got %b want 1", if_rvalid); end
    n_cmp++; if (if_rdata !== 32'h00500093) begin n_err++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
    step();
    // Address wrap: 0x1008 maps to the same word as 0x8.
    if_req = 1; if_addr = 32'h0000_1008;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 10'd2) begin n_err++; $display("FAIL fetch_wrap_addr: got %0d want 2", mem_addr); end
    step();
    if_req = 0;
    @(negedge clk);
    n_cmp++; if (if_rdata !== 32'h00500093) begin n_err++; $display("FAIL fetch_wrap_rdata: got %h want 00500093", if_rdata); end
    step();
  endtask

  task automatic test_simultaneous;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10; if_req = 1; if_addr = 32'h0;
    @(negedge clk);
    n_cmp++; if ({if_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL sim_c0_gnt: got %b want 01", {if_gnt, d_gnt}); end
    n_cmp++; if (mem_addr !== 10'd4) begin n_err++; $display("FAIL sim_c0_addr: got %0d want 4", mem_addr); end
    step();
    d_req = 0;
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL sim_c1_dresp: got %b/%h want 1/12345678", d_rvalid, d_rdata); end
    n_cmp++; if ({if_gnt, mem_addr} !== {1'b1, 10'd0}) begin n_err++; $display("FAIL sim_c1_if_gnt: got %b/%0d want 1/0", if_gnt, mem_addr); end
    step();
    if_req = 0;
    @(negedge clk);
    n_cmp++; if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h00000013, 1'b0}) begin n_err++; $display("FAIL sim_c2_ifresp: got %b/%h/%b want 1/00000013/0", if_rvalid, if_rdata, d_rvalid); end
    step();
  endtask

  task automatic test_starvation;
    logic [5:0] exp_d;
    logic [5:0] exp_i;
    exp_d = 6'b101111;
    exp_i = 6'b010000;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10; if_req = 1; if_addr = 32'h8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, d_gnt} !== {exp_i[c], exp_d[c]}) begin
        n_err++; $display("FAIL starve_cyc%0d: got if/d %b%b want %b%b", c, if_gnt, d_gnt, exp_i[c], exp_d[c]);
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_store;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if ({d_gnt, mem_en, mem_we, mem_be} !== 7'b1110011) begin n_err++; $display("FAIL store_cmd: got %b want 1110011", {d_gnt, mem_en, mem_we, mem_be}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {10'd8, 32'hDEADBEEF}) begin n_err++; $display("FAIL store_addr_data: got %0d/%h want 8/deadbeef", mem_addr, mem_wdata); end
    step();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h20;
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL store_ack: got %b/%h want 1/0", d_rvalid, d_rdata); end
    n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL store_b2b_gnt: got %b want 1", d_gnt); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000BEEF}) begin n_err++; $display("FAIL store_readback: got %b/%h want 1/0000beef", d_rvalid, d_rdata); end
    step();
  endtask

  task automatic test_flush;
    if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    n_cmp++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL flush_c0_gnt: got %b want 1", if_gnt); end
    step();
    if_flush = 1; if_addr = 32'h10;
    @(negedge clk);
    n_cmp++; if ({if_rvalid, if_gnt, mem_en} !== 3'b000) begin n_err++; $display("FAIL flush_c1: got rv/gnt/en %b want 000", {if_rvalid, if_gnt, mem_en}); end
    step();
    if_flush = 0;
    @(negedge clk);
    n_cmp++; if ({if_gnt, mem_addr} !== {1'b1, 10'd4}) begin n_err++; $display("FAIL flush_retry_gnt: got %b/%0d want 1/4", if_gnt, mem_addr); end
    step();
    if_req = 0;
    @(negedge clk);
    n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL flush_retry_resp: got %b/%h want 1/12345678", if_rvalid, if_rdata); end
    step();
    // Flush while data owns the response slot does not touch d_rvalid.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h8;
    step();
    idle(); if_flush = 1;
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h00500093}) begin n_err++; $display("FAIL flush_owner_d: got %b/%h want 1/00500093", d_rvalid, d_rdata); end
    step();
    idle();
  endtask

  task automatic test_reset_mid;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10; if_req = 1; if_addr = 32'h8;
    step();
    step();
    rst = 1;
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rstmid_drop: got %b/%h want 0/0", d_rvalid, d_rdata); end
    n_cmp++; if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin n_err++; $display("FAIL rstmid_gnt: got %b want 000", {if_gnt, d_gnt, mem_en}); end
    step();
    rst = 0;
    @(negedge clk);
    n_cmp++; if (dut.starve_cnt_q !== 3'd0) begin n_err++; $display("FAIL rstmid_starve_cnt: got %0d want 0", dut.starve_cnt_q); end
    n_cmp++; if ({d_gnt, if_gnt, d_rvalid} !== 3'b100) begin n_err++; $display("FAIL rstmid_resume: got %b want 100", {d_gnt, if_gnt, d_rvalid}); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL rstmid_resp: got %b/%h want 1/12345678", d_rvalid, d_rdata); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h00000013;
    mem[2] = 32'h00500093;
    mem[4] = 32'h12345678;
    rst = 1; if_addr = 0; d_addr = 0; d_wdata = 0;
    idle();
    step();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
